// File: rtl/cpu_types_pkg.sv
// cpu_types_pkg: shared CPU widths and the writeback queue entry type.
package cpu_types_pkg;
    localparam int XLEN               = 32;
    localparam int RADDR_W            = 5;
    localparam int WB_Q_DEPTH_DEFAULT = 2;

    typedef struct packed {
        logic [RADDR_W-1:0] rd_addr;
        logic [XLEN-1:0]    wb_data;
        logic               reg_wen;
        logic [XLEN-1:0]    pc_target;
    } wb_entry_t;
endpackage

// File: rtl/wb_fifo.sv
// wb_fifo: generic DEPTH x WIDTH in-order FIFO with head peek and occupancy count.
module wb_fifo #(
    parameter int DEPTH = 2,
    parameter int WIDTH = 8,
    localparam int AW = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push_i,
    input  logic             pop_i,
    input  logic [WIDTH-1:0] data_i,
    output logic [WIDTH-1:0] head_o,
    output logic             full_o,
    output logic             empty_o,
    output logic [AW:0]      count_o
);
    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_q, wr_d, rd_q, rd_d;
    logic [AW:0]      cnt_q, cnt_d;

    always_comb begin
        wr_d  = push_i ? wr_q + 1'b1 : wr_q;
        rd_d  = pop_i ? rd_q + 1'b1 : rd_q;
        cnt_d = cnt_q + (AW+1)'(push_i) - (AW+1)'(pop_i);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_q  <= '0;
            rd_q  <= '0;
            cnt_q <= '0;
        end else begin
            wr_q  <= wr_d;
            rd_q  <= rd_d;
            cnt_q <= cnt_d;
        end
    end

    // Storage needs no reset: reads are only meaningful while cnt_q != 0.
    always_ff @(posedge clk) begin
        if (push_i) mem_q[wr_q] <= data_i;
    end

    assign head_o  = mem_q[rd_q];
    assign full_o  = cnt_q == (AW+1)'(DEPTH);
    assign empty_o = cnt_q == '0;
    assign count_o = cnt_q;
endmodule

// File: rtl/wb_commit_queue.sv
// wb_commit_queue: buffers LSU results and commits one per cycle to regfile and IFU redirect.
// Optional WBU_BYPASS_EN: an empty queue forwards in_* straight to the commit outputs.
module wb_commit_queue #(
    parameter int XLEN    = cpu_types_pkg::XLEN,
    parameter int RADDR_W = cpu_types_pkg::RADDR_W,
    parameter int DEPTH   = cpu_types_pkg::WB_Q_DEPTH_DEFAULT
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [RADDR_W-1:0]       in_rd_addr,
    input  logic [XLEN-1:0]          in_wb_data,
    input  logic                     in_reg_wen,
    input  logic [XLEN-1:0]          in_pc_target,
    output logic                     rf_wen,
    output logic [RADDR_W-1:0]       rf_addr,
    output logic [XLEN-1:0]          rf_data,
    output logic                     redir_valid,
    input  logic                     redir_ready,
    output logic [XLEN-1:0]          redir_target,
    output logic [$clog2(DEPTH):0]   occupancy
);
    import cpu_types_pkg::*;

    wb_entry_t in_e, head_e, out_e;
    logic      full, empty, fifo_push, fifo_pop, out_valid, pop;

    assign in_e = '{rd_addr: in_rd_addr, wb_data: in_wb_data, reg_wen: in_reg_wen, pc_target: in_pc_target};

    wb_fifo #(.DEPTH(DEPTH), .WIDTH($bits(wb_entry_t))) u_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .push_i  (fifo_push),
        .pop_i   (fifo_pop),
        .data_i  (in_e),
        .head_o  (head_e),
        .full_o  (full),
        .empty_o (empty),
        .count_o (occupancy)
    );

    assign in_ready = !full;
    assign fifo_pop = !empty && redir_ready;

`ifdef WBU_BYPASS_EN
    logic byp;
    assign byp       = empty && in_valid;
    assign out_e     = byp ? in_e : head_e;
    assign out_valid = !empty || in_valid;
    // A bypassed entry that commits this cycle never occupies a slot.
    assign fifo_push = in_valid && in_ready && !(byp && redir_ready);
`else
    assign out_e     = head_e;
    assign out_valid = !empty;
    assign fifo_push = in_valid && in_ready;
`endif

    assign pop          = out_valid && redir_ready;
    assign redir_valid  = out_valid;
    assign redir_target = out_valid ? out_e.pc_target : '0;
    assign rf_addr      = out_valid ? out_e.rd_addr : '0;
    assign rf_data      = out_valid ? out_e.wb_data : '0;
    assign rf_wen       = pop && out_e.reg_wen && (out_e.rd_addr != '0);
endmodule

// File: tb/tb_wb_commit_queue.sv
// tb_wb_commit_queue: directed checks of reset, commit, backpressure, x0 and streaming order.
module tb_wb_commit_queue;
    logic        clk = 0;
    logic        rst_n = 0;
    logic        in_valid = 0, in_ready, in_reg_wen = 0;
    logic [4:0]  in_rd_addr = 0, rf_addr;
    logic [31:0] in_wb_data = 0, in_pc_target = 0, rf_data, redir_target;
    logic        rf_wen, redir_valid, redir_ready = 0;
    logic [1:0]  occupancy;
    int          tests = 0, errs = 0;

    typedef struct {
        logic [4:0]  rd;
        logic [31:0] data;
        logic        wen;
        logic [31:0] pc;
    } exp_t;
    exp_t sb[$];

    wb_commit_queue dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .in_rd_addr   (in_rd_addr),
        .in_wb_data   (in_wb_data),
        .in_reg_wen   (in_reg_wen),
        .in_pc_target (in_pc_target),
        .rf_wen       (rf_wen),
        .rf_addr      (rf_addr),
        .rf_data      (rf_data),
        .redir_valid  (redir_valid),
        .redir_ready  (redir_ready),
        .redir_target (redir_target),
        .occupancy    (occupancy)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (rst_n) begin
            assert (occupancy <= 2'd2);
            assert (!(in_ready && occupancy == 2'd2));
        end
    end

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        tests++;
        if (got !== exp) begin
            errs++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [4:0] rd, input logic [31:0] data,
                         input logic wen, input logic [31:0] pc);
        in_valid = v;
        in_rd_addr = rd;
        in_wb_data = data;
        in_reg_wen = wen;
        in_pc_target = pc;
    endtask

    initial begin
        int commits;
        exp_t e;
        // reset state
        repeat (2) @(negedge clk);
        chk("rst_occ", occupancy, 0);
        chk("rst_ready", in_ready, 1);
        chk("rst_rvalid", redir_valid, 0);
        chk("rst_wen", rf_wen, 0);
        chk("rst_addr", rf_addr, 0);
        chk("rst_data", rf_data, 0);
        chk("rst_target", redir_target, 0);
        rst_n = 1;

        // single op
        step();
        redir_ready = 1;
        drive(1, 5, 32'hDEADBEEF, 1, 32'h80000004);
        @(negedge clk);
`ifdef WBU_BYPASS_EN
        chk("single_byp_wen", rf_wen, 1);
        chk("single_byp_addr", rf_addr, 5);
        step();
        drive(0, 0, 0, 0, 0);
        @(negedge clk);
        chk("single_byp_occ", occupancy, 0);
`else
        chk("single_lat_rvalid", redir_valid, 0);
        chk("single_lat_wen", rf_wen, 0);
        step();
        drive(0, 0, 0, 0, 0);
        @(negedge clk);
        chk("single_wen", rf_wen, 1);
        chk("single_addr", rf_addr, 5);
        chk("single_data", rf_data, 32'hDEADBEEF);
        chk("single_target", redir_target, 32'h80000004);
        step();
        @(negedge clk);
        chk("single_occ0", occupancy, 0);
        chk("single_rvalid0", redir_valid, 0);
`endif

        // backpressure: three pushes into a two-deep queue
        step();
        redir_ready = 0;
        drive(1, 1, 32'h11, 1, 32'h100);
        step();
        drive(1, 2, 32'h22, 1, 32'h200);
        step();
        drive(1, 3, 32'h33, 1, 32'h300);
        @(negedge clk);
        chk("bp_full_ready", in_ready, 0);
        chk("bp_full_occ", occupancy, 2);
        chk("bp_head_addr", rf_addr, 1);
        chk("bp_stall_wen", rf_wen, 0);
        step();
        @(negedge clk);
        chk("bp_hold_valid", redir_valid, 1);
        chk("bp_hold_target", redir_target, 32'h100);
        redir_ready = 1;
        #1;
        chk("bp_c1_wen", rf_wen, 1);
        chk("bp_c1_addr", rf_addr, 1);
        chk("bp_c1_ready", in_ready, 0);
        step();
        @(negedge clk);
        chk("bp_c2_addr", rf_addr, 2);
        chk("bp_c2_data", rf_data, 32'h22);
        chk("bp_c2_ready", in_ready, 1);
        step();
        drive(0, 0, 0, 0, 0);
        @(negedge clk);
        chk("bp_c3_addr", rf_addr, 3);
        chk("bp_c3_target", redir_target, 32'h300);
        chk("bp_c3_wen", rf_wen, 1);
        step();
        @(negedge clk);
        chk("bp_drained", occupancy, 0);

        // x0 write suppressed, and wen=0 suppressed
        redir_ready = 0;
        drive(1, 0, 32'h1234, 1, 32'h400);
        step();
        drive(1, 7, 32'h5678, 0, 32'h500);
        step();
        drive(0, 0, 0, 0, 0);
        redir_ready = 1;
        @(negedge clk);
        chk("x0_rvalid", redir_valid, 1);
        chk("x0_wen", rf_wen, 0);
        chk("x0_target", redir_target, 32'h400);
        step();
        @(negedge clk);
        chk("nowen_addr", rf_addr, 7);
        chk("nowen_wen", rf_wen, 0);
        step();

        // reset mid-burst with two entries held
        redir_ready = 0;
        drive(1, 9, 32'h99, 1, 32'h900);
        step();
        drive(1, 10, 32'hAA, 1, 32'hA00);
        step();
        drive(0, 0, 0, 0, 0);
        @(negedge clk);
        chk("mr_pre_occ", occupancy, 2);
        redir_ready = 1;
        rst_n = 0;
        #1;
        chk("mr_occ", occupancy, 0);
        chk("mr_rvalid", redir_valid, 0);
        chk("mr_wen", rf_wen, 0);
        chk("mr_ready", in_ready, 1);
        @(negedge clk);
        rst_n = 1;
        step();

        // streaming with scoreboard
        redir_ready = 1;
        commits = 0;
        for (int i = 0; i < 100; i++) begin
            drive(1, 5'($urandom_range(0, 31)), $urandom, 1'($urandom_range(0, 1)), $urandom);
            @(negedge clk);
            if (in_valid && in_ready) sb.push_back('{in_rd_addr, in_wb_data, in_reg_wen, in_pc_target});
            chk("st_occ_le1", occupancy <= 2'd1, 1);
            if (redir_valid && redir_ready) begin
                chk("st_sb_nonempty", sb.size() > 0, 1);
                if (sb.size() > 0) begin
                    e = sb.pop_front();
                    chk("st_addr", rf_addr, e.rd);
                    chk("st_data", rf_data, e.data);
                    chk("st_target", redir_target, e.pc);
                    chk("st_wen", rf_wen, e.wen && e.rd != 0);
                    commits++;
                end
            end
            step();
        end
        chk("st_rate", commits >= 99, 1);
        drive(0, 0, 0, 0, 0);
        repeat (3) begin
            @(negedge clk);
            if (redir_valid && redir_ready && sb.size() > 0) begin
                e = sb.pop_front();
                chk("st_tail_addr", rf_addr, e.rd);
                chk("st_tail_data", rf_data, e.data);
                commits++;
            end
            step();
        end
        chk("st_total", commits, 100);
        chk("st_sb_empty", sb.size(), 0);
        chk("st_occ_end", occupancy, 0);

`ifdef WBU_BYPASS_EN
        drive(1, 9, 32'hCAFE, 1, 32'hC00);
        @(negedge clk);
        chk("byp_wen", rf_wen, 1);
        chk("byp_rvalid", redir_valid, 1);
        chk("byp_data", rf_data, 32'hCAFE);
        step();
        drive(0, 0, 0, 0, 0);
        @(negedge clk);
        chk("byp_occ", occupancy, 0);
`endif

        $display("[TB] %0d tests run, %0d failed", tests, errs);
        $finish;
    end
endmodule
